// File: rtl/pipe_stage_elastic_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic_if
// Valid/ready stream carrying one opaque payload and one control-bit vector.
//   valid : producer offers an entry
//   ready : consumer can take the entry
//   data  : payload, DATA_W bits
//   ctrl  : control bits, CTRL_W bits
// Modports: master drives valid/data/ctrl, slave drives ready.
// -----------------------------------------------------------------------------
interface pipe_stage_elastic_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (
        output valid,
        output data,
        output ctrl,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  ctrl,
        output ready
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
// Elastic inter-stage pipeline register with a 2-entry skid buffer. Upstream
// ready is a pure register output, so no combinational ready path crosses the
// stage. A flush squashes all held entries and zeroes their control bits. A
// saturating counter records cycles where downstream was ready but the stage
// had nothing to offer.
// Ports:
//   clk_i        : rising-edge clock
//   rst_ni       : asynchronous active-low reset
//   up_if        : upstream stream (slave), ready is registered
//   dn_if        : downstream stream (master), ctrl forced to 0 when not valid
//   flush_i      : synchronous squash of all held entries
//   bubble_clr_i : synchronous clear of the bubble counter
//   bubble_cnt_o : count of cycles with downstream ready and no valid entry
// -----------------------------------------------------------------------------
module pipe_stage_elastic #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    pipe_stage_elastic_if.slave  up_if,
    pipe_stage_elastic_if.master dn_if,
    input  logic                 flush_i,
    input  logic                 bubble_clr_i,
    output logic [CNT_W-1:0]     bubble_cnt_o
);

    // Encoding is {m_v, s_v}; the (0,1) pattern has no enumerator.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StHalf  = 2'b10,
        StFull  = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic m_v, s_v;
    logic accept, drain;
    logic load_main, load_skid, skid_to_main;

    logic [DATA_W-1:0] m_data_q, s_data_q;
    logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
    logic [CNT_W-1:0]  bubble_q;

    assign m_v    = state_q[1];
    assign s_v    = state_q[0];
    assign accept = up_if.valid & ~s_v;
    assign drain  = m_v & dn_if.ready;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath load decode
    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush_i) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d   = StHalf;
                        load_main = 1'b1;
                    end
                end
                StHalf: begin
                    if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_d   = StFull;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    // in_ready is low here, so only a drain can move things
                    if (drain) begin
                        state_d      = StHalf;
                        skid_to_main = 1'b1;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        up_if.ready  = ~s_v;
        dn_if.valid  = m_v;
        dn_if.data   = m_data_q;
        dn_if.ctrl   = m_v ? m_ctrl_q : '0;
        bubble_cnt_o = bubble_q;
    end

    // Entry storage; data survives a flush, control bits do not
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_data_q <= '0;
            m_ctrl_q <= '0;
            s_data_q <= '0;
            s_ctrl_q <= '0;
        end else if (flush_i) begin
            m_ctrl_q <= '0;
            s_ctrl_q <= '0;
        end else begin
            if (load_main) begin
                m_data_q <= up_if.data;
                m_ctrl_q <= up_if.ctrl;
            end else if (skid_to_main) begin
                m_data_q <= s_data_q;
                m_ctrl_q <= s_ctrl_q;
            end
            if (load_skid) begin
                s_data_q <= up_if.data;
                s_ctrl_q <= up_if.ctrl;
            end
        end
    end

    // Saturating bubble counter; clear wins over increment, flush leaves it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bubble_q <= '0;
        end else if (bubble_clr_i) begin
            bubble_q <= '0;
        end else if (dn_if.ready && !m_v && (bubble_q != '1)) begin
            bubble_q <= bubble_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
// Self-checking bench: directed vector table, bubble counter and asynchronous
// reset sequences, then a queue-based reference model for streaming and
// random traffic. A second instance with a 2-bit counter checks saturation.
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;
    localparam int unsigned NW = 16;

    logic          clk    = 1'b0;
    logic          rst_ni = 1'b1;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;
    logic          flush;
    logic          bubble_clr;
    logic [NW-1:0] bubble_cnt;
    logic [1:0]    bubble_cnt2;

    int checks   = 0;
    int failures = 0;

    pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
    pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();
    pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) up2_if ();
    pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) dn2_if ();

    assign up_if.valid   = in_valid;
    assign up_if.data    = in_data;
    assign up_if.ctrl    = in_ctrl;
    assign dn_if.ready   = out_ready;
    assign up2_if.valid  = in_valid;
    assign up2_if.data   = in_data;
    assign up2_if.ctrl   = in_ctrl;
    assign dn2_if.ready  = out_ready;

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .up_if        (up_if),
        .dn_if        (dn_if),
        .flush_i      (flush),
        .bubble_clr_i (bubble_clr),
        .bubble_cnt_o (bubble_cnt)
    );

    pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(2)) dut2 (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .up_if        (up2_if),
        .dn_if        (dn2_if),
        .flush_i      (flush),
        .bubble_clr_i (bubble_clr),
        .bubble_cnt_o (bubble_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ordy;
        logic          fl;
        logic          ov;
        logic [DW-1:0] od;
        logic [CW-1:0] oc;
        logic          ir;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } ent_t;

    vec_t          vq[$];
    ent_t          sb[$];
    logic [NW-1:0] exp_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic fl, input logic clr);
        in_valid   = iv;
        in_data    = d;
        in_ctrl    = c;
        out_ready  = ordy;
        flush      = fl;
        bubble_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle against the reference queue: push on accept, pop and compare on drain
    task automatic sb_cycle(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                            input logic ordy, input logic fl, input logic clr,
                            output logic accepted);
        logic acc, drn;
        ent_t e;
        drive(iv, d, c, ordy, fl, clr);
        acc = iv && (sb.size() < 2);
        drn = ordy && (sb.size() > 0);
        if (clr) begin
            exp_cnt = '0;
        end else if (ordy && (sb.size() == 0) && (exp_cnt != '1)) begin
            exp_cnt = exp_cnt + 1'b1;
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (drn) begin
                e = sb.pop_front();
                chk("drain_data", 64'(dn_if.data), 64'(e.data));
                chk("drain_ctrl", 64'(dn_if.ctrl), 64'(e.ctrl));
            end
            if (acc) begin
                e.data = d;
                e.ctrl = c;
                sb.push_back(e);
            end
        end
        accepted = acc && !fl;
        tick();
        chk("sb_out_valid", 64'(dn_if.valid), 64'(sb.size() != 0));
        chk("sb_in_ready", 64'(up_if.ready), 64'(sb.size() < 2));
        chk("sb_bubble_cnt", 64'(bubble_cnt), 64'(exp_cnt));
        chk("illegal_state", 64'(!dn_if.valid && !up_if.ready), 64'(0));
        if (sb.size() != 0) begin
            chk("sb_out_data", 64'(dn_if.data), 64'(sb[0].data));
            chk("sb_out_ctrl", 64'(dn_if.ctrl), 64'(sb[0].ctrl));
        end else begin
            chk("sb_out_ctrl_idle", 64'(dn_if.ctrl), 64'(0));
        end
    endtask

    initial begin
        logic [DW-1:0] junk;
        logic          acc;
        logic          pend_v;
        logic [DW-1:0] pend_d;
        logic [CW-1:0] pend_c;
        logic          fl;
        logic          clr;

        junk = 32'hDEAD_BEEF;
        //            iv  d        c     ordy  fl  |  ov  od        oc    ir
        vq.push_back(vec_t'{1'b1, 32'h1234, 3'h5, 1'b1, 1'b0, 1'b1, 32'h1234, 3'h5, 1'b1});
        vq.push_back(vec_t'{1'b0, junk,     3'h7, 1'b1, 1'b0, 1'b0, 32'h0,    3'h0, 1'b1});
        vq.push_back(vec_t'{1'b1, 32'hA,    3'h1, 1'b0, 1'b0, 1'b1, 32'hA,    3'h1, 1'b1});
        vq.push_back(vec_t'{1'b1, 32'hB,    3'h2, 1'b0, 1'b0, 1'b1, 32'hA,    3'h1, 1'b0});
        vq.push_back(vec_t'{1'b1, 32'hC,    3'h3, 1'b0, 1'b0, 1'b1, 32'hA,    3'h1, 1'b0});
        vq.push_back(vec_t'{1'b1, 32'hC,    3'h3, 1'b1, 1'b0, 1'b1, 32'hB,    3'h2, 1'b1});
        vq.push_back(vec_t'{1'b1, 32'hC,    3'h3, 1'b1, 1'b0, 1'b1, 32'hC,    3'h3, 1'b1});
        vq.push_back(vec_t'{1'b0, junk,     3'h7, 1'b1, 1'b0, 1'b0, 32'h0,    3'h0, 1'b1});
        vq.push_back(vec_t'{1'b1, 32'hA,    3'h1, 1'b0, 1'b0, 1'b1, 32'hA,    3'h1, 1'b1});
        vq.push_back(vec_t'{1'b1, 32'hB,    3'h2, 1'b0, 1'b0, 1'b1, 32'hA,    3'h1, 1'b0});
        vq.push_back(vec_t'{1'b1, 32'hC,    3'h3, 1'b1, 1'b1, 1'b0, 32'h0,    3'h0, 1'b1});
        vq.push_back(vec_t'{1'b0, junk,     3'h7, 1'b1, 1'b0, 1'b0, 32'h0,    3'h0, 1'b1});
        vq.push_back(vec_t'{1'b1, 32'hD,    3'h4, 1'b0, 1'b0, 1'b1, 32'hD,    3'h4, 1'b1});
        vq.push_back(vec_t'{1'b1, 32'hE,    3'h5, 1'b1, 1'b0, 1'b1, 32'hE,    3'h5, 1'b1});
        vq.push_back(vec_t'{1'b0, junk,     3'h7, 1'b0, 1'b0, 1'b1, 32'hE,    3'h5, 1'b1});
        vq.push_back(vec_t'{1'b0, junk,     3'h7, 1'b0, 1'b1, 1'b0, 32'h0,    3'h0, 1'b1});
        vq.push_back(vec_t'{1'b1, 32'hF,    3'h6, 1'b1, 1'b0, 1'b1, 32'hF,    3'h6, 1'b1});
        vq.push_back(vec_t'{1'b0, junk,     3'h7, 1'b1, 1'b0, 1'b0, 32'h0,    3'h0, 1'b1});

        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 64'(dn_if.valid), 64'(0));
        chk("rst_out_data", 64'(dn_if.data), 64'(0));
        chk("rst_out_ctrl", 64'(dn_if.ctrl), 64'(0));
        chk("rst_in_ready", 64'(up_if.ready), 64'(1));
        chk("rst_bubble_cnt", 64'(bubble_cnt), 64'(0));
        @(negedge clk);
        rst_ni = 1'b1;

        // Directed vector table
        foreach (vq[i]) begin
            drive(vq[i].iv, vq[i].d, vq[i].c, vq[i].ordy, vq[i].fl, 1'b0);
            tick();
            chk($sformatf("vec%0d_out_valid", i), 64'(dn_if.valid), 64'(vq[i].ov));
            chk($sformatf("vec%0d_out_ctrl", i), 64'(dn_if.ctrl), 64'(vq[i].oc));
            chk($sformatf("vec%0d_in_ready", i), 64'(up_if.ready), 64'(vq[i].ir));
            if (vq[i].ov) begin
                chk($sformatf("vec%0d_out_data", i), 64'(dn_if.data), 64'(vq[i].od));
            end
        end

        // Bubble counter: clear, count, saturate, clear priority, flush keeps it
        drive(1'b0, junk, '0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("bub_clr", 64'(bubble_cnt), 64'(0));
        chk("bub_clr_w2", 64'(bubble_cnt2), 64'(0));
        drive(1'b0, junk, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("bub_5", 64'(bubble_cnt), 64'(5));
        chk("bub_sat_5", 64'(bubble_cnt2), 64'(3));
        tick();
        chk("bub_6", 64'(bubble_cnt), 64'(6));
        chk("bub_sat_6", 64'(bubble_cnt2), 64'(3));
        drive(1'b0, junk, '0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("bub_clr_prio", 64'(bubble_cnt), 64'(0));
        drive(1'b0, junk, '0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("bub_flush_keeps", 64'(bubble_cnt), 64'(1));

        // Asynchronous reset while HALF
        drive(1'b1, 32'h77, 3'h1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ar_half_valid", 64'(dn_if.valid), 64'(1));
        drive(1'b0, junk, '0, 1'b0, 1'b0, 1'b0);
        #3 rst_ni = 1'b0;
        #1;
        chk("ar_out_valid", 64'(dn_if.valid), 64'(0));
        chk("ar_in_ready", 64'(up_if.ready), 64'(1));
        chk("ar_bubble_cnt", 64'(bubble_cnt), 64'(0));
        chk("ar_out_data", 64'(dn_if.data), 64'(0));
        chk("ar_out_ctrl", 64'(dn_if.ctrl), 64'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        sb.delete();
        exp_cnt = '0;
        #1;

        // Streaming 0..9 with out_ready held high
        for (int i = 0; i < 10; i++) begin
            sb_cycle(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, 1'b0, acc);
        end
        for (int i = 0; i < 2; i++) begin
            sb_cycle(1'b0, junk, '0, 1'b1, 1'b0, 1'b0, acc);
        end

        // Random stress; an unaccepted offer is held until taken or flushed
        pend_v = 1'b0;
        pend_d = '0;
        pend_c = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!pend_v) begin
                pend_v = 1'($urandom_range(0, 1));
                pend_d = $urandom();
                pend_c = CW'($urandom_range(0, 7));
            end
            fl  = ($urandom_range(0, 99) < 5);
            clr = ($urandom_range(0, 99) < 1);
            sb_cycle(pend_v, pend_v ? pend_d : junk, pend_c, 1'($urandom_range(0, 1)),
                     fl, clr, acc);
            if (acc || fl) pend_v = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic inter-stage pipeline register for the CPU datapath. It replaces fixed-field, enable-gated stage latches.
- Carries one opaque data payload and one control-bit vector per entry, under a valid/ready handshake.
- A 2-entry skid buffer makes the upstream ready signal a pure register output, so there is no combinational ready path through the stage.
- Supports a flush that kills in-flight control bits (for branch or exception squash) and keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 64: payload width (for example PC, ALU result or write-back data). Minimum 1.
- CTRL_W, 8: control-bit width (for example register-write enable or HI/LO write enable). Zeroed on flush or bubble. Minimum 1.
- CNT_W, 16: bubble counter width. Minimum 2.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset (asserted when 0).
- in_valid, input, 1: upstream offers an entry.
- in_ready, output, 1: stage can accept an entry. Registered.
- in_data, input, DATA_W: upstream payload.
- in_ctrl, input, CTRL_W: upstream control bits.
- flush, input, 1: synchronous squash of all held entries.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: downstream accepts the head entry.
- out_data, output, DATA_W: head payload.
- out_ctrl, output, CTRL_W: head control bits. Forced to 0 when out_valid=0.
- bubble_cnt, output, CNT_W: count of cycles with out_ready=1 and out_valid=0.
- bubble_clr, input, 1: synchronous clear of bubble_cnt.

Behaviour:
- Storage:
  - main entry {m_v, m_data, m_ctrl} drives the out_* ports.
  - skid entry {s_v, s_data, s_ctrl}.
- Handshake events:
  - accept = in_valid & in_ready.
  - drain = out_valid & out_ready.
- States are derived from {m_v, s_v}:
  - EMPTY (0,0)
  - HALF (1,0)
  - FULL (1,1)
  - (0,1) is illegal and must never occur.
- Outputs: out_valid = m_v; in_ready = ~s_v (registered state bit, no combinational dependence on out_ready).
- Transitions on posedge clk when flush=0:
  - EMPTY: accept loads main, giving HALF. Otherwise stay EMPTY.
  - HALF, accept & drain: main is overwritten with the input, stay HALF.
  - HALF, accept & ~drain: input goes to skid, giving FULL.
  - HALF, ~accept & drain: giving EMPTY.
  - HALF, neither: hold.
  - FULL, drain: skid moves to main, s_v=0, giving HALF. in_ready=0 in FULL, so accept cannot occur.
  - FULL, ~drain: hold everything.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1 entry per cycle sustained while out_ready=1.
- Ordering: strict FIFO. The skid entry never overtakes main.
- Flush:
  - On any edge with flush=1: m_v=0, s_v=0, m_ctrl=0, s_ctrl=0.
  - Data registers keep their values (don't-care).
  - Flush has priority over accept and drain in the same cycle: the incoming entry is dropped and the drain is ignored.
  - in_ready is 1 on the cycle after a flush.
- Bubble counter:
  - Increments on each edge where out_ready=1 and out_valid=0.
  - Saturates at all-ones; no wrap.
  - bubble_clr=1 sets it to 0, with priority over increment.
  - A flush does not clear it.
- Reset (rst=0, asynchronous):
  - m_v=0, s_v=0, all data and control registers 0, bubble_cnt=0.
  - Resulting outputs: out_valid=0, out_data=0, out_ctrl=0, in_ready=1.
  - Reset mid-transfer discards both entries.
  - Deassertion is synchronised externally. The block assumes a clean release relative to clk.
- Input rules:
  - in_data and in_ctrl are sampled only on accept.
  - When in_ready=0, upstream must hold the offer.
  - X on inputs while in_valid=0 must not propagate to the outputs.

Test Plan:
- Reset then pass-through:
  - Stimulus: rst=0 then 1; in_valid=1, in_data=0x1234, in_ctrl=0x05; out_ready=1.
  - Required: the next cycle shows out_valid=1, out_data=0x1234, out_ctrl=0x05, in_ready=1.
  - Required: streaming 0..9 on successive cycles appears in order with no gap.
- Backpressure and skid:
  - Stimulus: out_ready=0; send A=0xA then B=0xB.
  - Required: in_ready drops to 0 after B; the stage stays FULL; out_data=0xA.
  - Stimulus: raise out_ready.
  - Required: A then B emerge on consecutive cycles; in_ready returns to 1 after the first drain.
- Flush priority:
  - Stimulus: in FULL (A, B), flush=1 with in_valid=1 (C) and out_ready=1 in the same cycle.
  - Required: the next cycle shows out_valid=0, out_ctrl=0, in_ready=1; A, B and C never appear.
- Bubble counter:
  - Stimulus: out_ready=1, in_valid=0 for 5 cycles.
  - Required: bubble_cnt=5.
  - Stimulus: bubble_clr=1 for 1 cycle.
  - Required: bubble_cnt=0.
  - Stimulus: CNT_W=2, 6 idle cycles.
  - Required: bubble_cnt saturates at 3.
- Asynchronous reset mid-operation:
  - Stimulus: assert rst=0 between clock edges while in HALF.
  - Required: out_valid=0 and in_ready=1 immediately, without waiting for an edge; bubble_cnt=0.
- Random stress:
  - Stimulus: random in_valid, out_ready and flush (5%) over 10k cycles, DATA_W=32, CTRL_W=3.
  - Required: the scoreboard sees in-order, loss-free delivery of every accepted, non-flushed entry.
  - Required: state (m_v=0, s_v=1) never occurs.
